axis_pkt_rr_arb: RTL

- Packet-granular round-robin arbiter that shares one AXI-Stream sink (the FIFO under test in the fifo/fifo_hdr/fifo_drp benches) between N AXI-Stream requesters.
- Locks a grant from the first beat of a packet through the tlast beat.
- Exposes the grant index for header insertion and scoreboarding.

---
 rtl/axis_pkt_rr_arb.sv | 79 +++++++
 1 files changed

// File: rtl/axis_pkt_rr_arb.sv
// axis_pkt_rr_arb: packet-locked round-robin arbiter sharing one AXI-Stream sink between N requesters.
// Define AXIS_ARB_TID_EN to add the m_tid source-index output.
module axis_pkt_rr_arb #(
  parameter int N = 4,
  parameter int DW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_tvalid,
  output logic [N-1:0]    s_tready,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tlast,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tlast,
  output logic            grant_vld,
`ifdef AXIS_ARB_TID_EN
  output logic [IW-1:0]   m_tid,
`endif
  output logic [IW-1:0]   grant_idx
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic grant_vld_q, grant_vld_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d, ptr_q, ptr_d, sel, cand;
  logic lock;
  assign lock = state_q == LOCK;
  assign grant_vld = grant_vld_q;
  assign grant_idx = grant_idx_q;
  assign m_tvalid = lock & s_tvalid[grant_idx_q];
  assign m_tlast = lock & s_tlast[grant_idx_q];
  assign m_tdata = m_tvalid ? s_tdata[grant_idx_q*DW +: DW] : '0;
`ifdef AXIS_ARB_TID_EN
  assign m_tid = lock ? grant_idx_q : '0;
`endif
  always_comb begin
    s_tready = '0;
    s_tready[grant_idx_q] = lock & m_tready;
  end
  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    sel = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (s_tvalid[cand]) sel = cand;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_vld_d = grant_vld_q;
    grant_idx_d = grant_idx_q;
    ptr_d = ptr_q;
    if (!lock && |s_tvalid) begin
      state_d = LOCK;
      grant_vld_d = 1'b1;
      grant_idx_d = sel;
    end else if (lock && m_tvalid && m_tready && m_tlast) begin
      state_d = IDLE;
      grant_vld_d = 1'b0;
      ptr_d = grant_idx_q == IW'(N - 1) ? '0 : grant_idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_vld_q <= 1'b0;
      grant_idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_vld_q <= grant_vld_d;
      grant_idx_q <= grant_idx_d;
      ptr_q <= ptr_d;
    end
  end
endmodule
